// File: rtl/iter_shift_unit_pkg.sv
// Shared definitions for iter_shift_unit: shift op encodings and FSM states.
package iter_shift_unit_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/iter_shift_unit_shift_step.sv
// Combinational single-step shifter: shifts operand by amount positions.
// SHIFT_ROTATE_EN enables the rotate-right path for op 11; otherwise op 11 acts as SRL.
module shift_step
    import iter_shift_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [1:0]         op,
    input  logic               fill,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill_lo;
    logic [WIDTH-1:0] fill_hi;
    logic [WIDTH-1:0] right;
`ifdef SHIFT_ROTATE_EN
    logic [2*WIDTH-1:0] doubled;
`endif

    // Masks cover exactly the positions vacated by this step's shift.
    always_comb begin
        ones    = '1;
        fill_lo = fill ? ~(ones << amount) : '0;
        fill_hi = fill ? ~(ones >> amount) : '0;
        right   = (operand >> amount) | fill_hi;
`ifdef SHIFT_ROTATE_EN
        doubled = {operand, operand} >> amount;
`endif
        result  = right;
        case (op)
            SH_SLL: result = (operand << amount) | fill_lo;
            SH_SRL: result = right;
            SH_SRA: result = right;
`ifdef SHIFT_ROTATE_EN
            SH_ROR: result = doubled[WIDTH-1:0];
`else
            SH_ROR: result = right;
`endif
            default: result = right;
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift unit: shifts up to STEP positions per BUSY cycle with valid/ready on both sides.
// Optional macro SHIFT_ROTATE_EN adds rotate-right for op 11 (see shift_step).
module iter_shift_unit
    import iter_shift_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   work_reg;
    logic [SHAMT_W-1:0] remaining;
    logic [1:0]         op_q;
    logic               fill_q;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   step_out;

    always_comb begin
        k = remaining;
        if (32'(remaining) > 32'(STEP)) begin
            k = STEP_K;
        end
    end

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift_step (
        .operand (work_reg),
        .amount  (k),
        .op      (op_q),
        .fill    (fill_q),
        .result  (step_out)
    );

    // Fill is latched once from the accepted operand and reused every step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work_reg  <= '0;
            remaining <= '0;
            op_q      <= SH_SLL;
            fill_q    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_reg  <= in_data;
                        remaining <= in_shamt;
                        op_q      <= in_op;
                        fill_q    <= (in_op == SH_SRA) ? in_data[WIDTH-1] : 1'b0;
                    end
                end
                BUSY: begin
                    work_reg  <= step_out;
                    remaining <= remaining - k;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    next_state = (in_shamt != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (remaining == k) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign out_data = work_reg;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: two instances (STEP=1 and STEP=4), directed and random requests.
// Honours SHIFT_ROTATE_EN when choosing the expected behaviour of op 11.
module tb_iter_shift_unit;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0][W-1:0] in_data;
    logic [1:0][4:0] in_shamt;
    logic [1:0][1:0] in_op;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0][W-1:0] out_data;
    logic [1:0]      busy;

    int checks = 0;
    int errors = 0;

    iter_shift_unit #(.WIDTH(W), .SHAMT_W(5), .STEP(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_shamt(in_shamt[0]), .in_op(in_op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    iter_shift_unit #(.WIDTH(W), .SHAMT_W(5), .STEP(4)) dut_s4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_shamt(in_shamt[1]), .in_op(in_op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int idx);
        return (idx == 0) ? 1 : 4;
    endfunction

    // Reference result straight from the shift definitions, one whole shift at once.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic [1:0] op);
        logic [W-1:0] r;
        case (op)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = W'($signed(d) >>> s);
`ifdef SHIFT_ROTATE_EN
            default: r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
`else
            default: r = d >> s;
`endif
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for in_ready, presents one request for one edge, then withdraws it.
    task automatic applyStimulus(input int idx, input logic [W-1:0] d, input int s, input logic [1:0] op);
        int waited;
        waited = 0;
        while (in_ready[idx] !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check_eq("ready_before_accept", W'(in_ready[idx]), W'(1));
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        in_shamt[idx] = 5'(s);
        in_op[idx]    = op;
        tick();
        in_valid[idx] = 1'b0;
        in_data[idx]  = $urandom;
        in_shamt[idx] = 5'($urandom);
        in_op[idx]    = 2'($urandom);
    endtask

    // Checks latency, busy, result, stability under backpressure and release.
    task automatic checkOutput(input int idx, input int s, input int hold, input logic [W-1:0] exp);
        int cycles;
        int exp_lat;
        logic busy_ok;
        busy_ok = 1'b1;
        cycles  = 1;
        exp_lat = 1 + (s + step_of(idx) - 1) / step_of(idx);
        while (out_valid[idx] !== 1'b1 && cycles < 100) begin
            if (busy[idx] !== 1'b1 || in_ready[idx] !== 1'b0) busy_ok = 1'b0;
            tick();
            cycles++;
        end
        check_eq("latency", W'(cycles), W'(exp_lat));
        check_eq("busy_while_shifting", W'(busy_ok), W'(1));
        check_eq("result", out_data[idx], exp);
        check_eq("busy_in_done", W'(busy[idx]), W'(1));
        out_ready[idx] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check_eq("hold_valid", W'(out_valid[idx]), W'(1));
            check_eq("hold_data", out_data[idx], exp);
            check_eq("hold_in_ready", W'(in_ready[idx]), W'(0));
        end
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        check_eq("valid_after_handshake", W'(out_valid[idx]), W'(0));
        check_eq("ready_after_handshake", W'(in_ready[idx]), W'(1));
    endtask

    task automatic run(input int idx, input logic [W-1:0] d, input int s, input logic [1:0] op,
                       input int hold, input logic [W-1:0] exp);
        applyStimulus(idx, d, s, op);
        checkOutput(idx, s, hold, exp);
    endtask

    initial begin
        logic [W-1:0] d;
        int           s;
        logic [1:0]   op;
        logic         saw_valid;

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = '0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_out_valid", W'(out_valid[i]), W'(0));
            check_eq("reset_out_data", out_data[i], '0);
            check_eq("reset_busy", W'(busy[i]), W'(0));
            check_eq("reset_in_ready", W'(in_ready[i]), W'(0));
        end
        rst = 1'b0;
        #1;
        check_eq("ready_after_reset_s1", W'(in_ready[0]), W'(1));
        check_eq("ready_after_reset_s4", W'(in_ready[1]), W'(1));

        $display("[TB] directed requests");
        run(0, 32'h8000_0010, 4, 2'b10, 0, 32'hF800_0001);
        run(0, 32'h8000_0010, 4, 2'b01, 1, 32'h0800_0001);
        run(0, 32'h0000_0001, 31, 2'b00, 0, 32'h8000_0000);
        run(0, 32'h1234_5678, 0, 2'b10, 0, 32'h1234_5678);
        run(1, 32'h1234_5678, 0, 2'b00, 0, 32'h1234_5678);
        run(1, 32'hF000_0000, 7, 2'b10, 3, 32'hFFE0_0000);
        run(0, 32'h8000_0000, 31, 2'b10, 0, 32'hFFFF_FFFF);
        run(1, 32'h8000_0000, 31, 2'b01, 0, 32'h0000_0001);
`ifdef SHIFT_ROTATE_EN
        run(0, 32'h0000_0001, 1, 2'b11, 0, 32'h8000_0000);
        run(1, 32'h0000_00F1, 6, 2'b11, 0, 32'hC400_0003);
`else
        run(0, 32'h0000_0001, 1, 2'b11, 0, 32'h0000_0000);
        run(1, 32'h8000_00F1, 6, 2'b11, 0, 32'h0200_0003);
`endif

        $display("[TB] reset during shifting");
        applyStimulus(0, 32'h0000_0003, 20, 2'b00);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_out_valid", W'(out_valid[0]), W'(0));
        check_eq("midrst_busy", W'(busy[0]), W'(0));
        check_eq("midrst_in_ready_low", W'(in_ready[0]), W'(0));
        rst = 1'b0;
        #1;
        check_eq("midrst_in_ready_high", W'(in_ready[0]), W'(1));
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid[0] === 1'b1) saw_valid = 1'b1;
        end
        check_eq("midrst_no_result", W'(saw_valid), W'(0));
        run(0, 32'h0000_0003, 20, 2'b00, 1, 32'h0030_0000);

        $display("[TB] random requests");
        for (int i = 0; i < 40; i++) begin
            d  = $urandom;
            s  = $urandom_range(0, 31);
            op = 2'($urandom_range(0, 3));
            run(i % 2, d, s, op, $urandom_range(0, 2), model(d, s, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Parametrised, multi-cycle shift unit for the MIPS datapath. It consumes a shift amount produced by the 5-bit extension stage and performs logical-left, logical-right or arithmetic-right shifts. Zero fill or sign fill is applied per cycle, STEP bit positions at a time. It sits between ID/EX operand muxing and the EX result mux, using a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥2)
- SHAMT_W, $clog2(WIDTH), shift-amount width
- STEP, 1, maximum bit positions shifted per BUSY cycle (1..WIDTH)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount, unsigned
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- busy  out  1  high in BUSY or DONE

## Operation
- FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data into the working register, in_shamt into the remaining counter, in_op, and fill bit.
  - Fill bit is in_data[WIDTH-1] for SRA and 0 otherwise.
  - Next state is BUSY if in_shamt≠0, otherwise DONE.
- BUSY, per cycle:
  - k = min(STEP, remaining).
  - Shift the working register by k in the op's direction.
  - Vacated positions get the fill bit; for ROR they get the bits shifted out.
  - remaining -= k.
  - Go to DONE when the new remaining value is 0.
- DONE:
  - out_valid=1 and out_data=working register.
  - On out_ready, go to IDLE.
  - in_ready=0, so there is no overlap or bypass.
- The fill bit is taken from the captured operand only, never re-sampled.
- SRA with remaining ≥ WIDTH is not possible, since SHAMT_W bounds the shift. A shift of WIDTH-1 yields all fill bits except bit 0.
- Inputs are ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst is released.
- Latency from accept edge to out_valid high is 1+ceil(shamt/STEP) cycles. A shift of 0 takes 1 cycle.
- out_data is stable while out_valid=1 and out_ready=0.
- Back-to-back throughput: the next accept is possible in the cycle after the out_ready handshake.
- Reset during BUSY or DONE returns to IDLE next edge and discards the result. out_valid drops at that edge.
- STEP ≥ WIDTH makes every nonzero shift complete in exactly one BUSY cycle.

## Configuration
- SHIFT_ROTATE_EN defined:
  - op 11 performs rotate-right by shamt.
  - Fill comes from the wrapped-out bits.
- SHIFT_ROTATE_EN undefined:
  - op 11 is decoded as SRL.
  - No rotate datapath is synthesised.

## Structure
- Shared package contains:
  - op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11;
  - FSM state enum (IDLE/BUSY/DONE).
- One sub-module, shift_step. It is combinational: given reg, k, op and fill bit, it returns the shifted reg. It is instantiated once and isolates the per-cycle datapath for unit testing.

## Test plan
- WIDTH=32, STEP=1, SRA in_data=0x80000010, shamt=4 -> out_data=0xF8000001 after 5 cycles; busy high for those cycles.
- STEP=1, SRL same operand, shamt=4 -> 0x08000001; SLL 0x00000001, shamt=31 -> 0x80000000 after 32 cycles.
- shamt=0, any op, in_data=0x12345678 -> out_data=0x12345678, out_valid on the 1st cycle after accept.
- STEP=4, SRA 0xF0000000, shamt=7 -> 0xFFE00000 after 1+2 cycles. Hold out_ready=0 for 3 cycles: data stable and in_ready stays 0.
- Assert rst mid-BUSY -> out_valid never rises, in_ready=1 the cycle after rst drops, and the next request completes correctly.
- With SHIFT_ROTATE_EN, ROR 0x00000001 shamt=1 -> 0x80000000. Without it, the same stimulus -> 0x00000000.
